// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: ALU select codes, major opcodes
// and the default datapath width.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_MUL   = 4'b1100;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Combinational operand-forwarding selector for one source register.
// Ports:
//   rs            source register index
//   rf_data       register file read data for rs
//   exmem_we/rd/result  EX/MEM writeback (highest priority)
//   memwb_we/rd/result  MEM/WB writeback
//   operand       selected operand value
// r0 never forwards; it always reads the register file value.
module fwd_mux #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [XLEN-1:0]       rf_data,
  input  logic                  exmem_we,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic                  memwb_we,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_result,
  output logic [XLEN-1:0]       operand
);

  logic rs_nonzero;

  always_comb begin
    rs_nonzero = (rs != '0);
    operand    = rf_data;
    if (exmem_we && (exmem_rd == rs) && rs_nonzero)
      operand = exmem_result;
    else if (memwb_we && (memwb_rd == rs) && rs_nonzero)
      operand = memwb_result;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the ALU: decodes opcode/funct3/funct7 into
// an ALU select code, picks forwarded operands and registers everything
// behind a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_opcode/funct3/funct7, in_rs1/rs2/rd, in_rs1_data/rs2_data, in_imm
//                         decoded instruction fields and register data
//   exmem_*, memwb_*      forwarding sources
//   flush                 kill held and incoming instruction
//   out_valid/out_ready   downstream handshake
//   data_a, data_b, alu_select, store_data, out_rd, out_reg_we, out_illegal
//                         registered ALU issue bundle
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  exmem_we,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic                  memwb_we,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_result,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       data_a,
  output logic [XLEN-1:0]       data_b,
  output logic [3:0]            alu_select,
  output logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_we,
  output logic                  out_illegal
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      dec_sel;
  logic [XLEN-1:0] dec_b;
  logic            dec_we;
  logic            dec_ill;
  logic            capture;

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs           (in_rs1),
    .rf_data      (in_rs1_data),
    .exmem_we     (exmem_we),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_we     (memwb_we),
    .memwb_rd     (memwb_rd),
    .memwb_result (memwb_result),
    .operand      (op_a)
  );

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs           (in_rs2),
    .rf_data      (in_rs2_data),
    .exmem_we     (exmem_we),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_we     (memwb_we),
    .memwb_rd     (memwb_rd),
    .memwb_result (memwb_result),
    .operand      (op_b)
  );

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    dec_sel = ALU_PASSB;
    dec_b   = in_imm;
    dec_we  = 1'b0;
    dec_ill = 1'b0;
    case (in_opcode)
      OP_R: begin
        dec_b  = op_b;
        dec_we = 1'b1;
        case ({in_funct3, in_funct7})
          {3'b000, 7'b0000000}: dec_sel = ALU_ADD;
          {3'b000, 7'b0100000}: dec_sel = ALU_SUB;
          {3'b000, 7'b0000001}: dec_sel = ALU_MUL;
          {3'b111, 7'b0000000}: dec_sel = ALU_AND;
          {3'b110, 7'b0000000}: dec_sel = ALU_OR;
          {3'b001, 7'b0000000}: dec_sel = ALU_SLL;
          default: begin
            dec_we  = 1'b0;
            dec_ill = 1'b1;
          end
        endcase
      end
      OP_I: begin
        dec_we = 1'b1;
        case (in_funct3)
          3'b000: dec_sel = ALU_ADD;
          3'b111: dec_sel = ALU_AND;
          3'b110: dec_sel = ALU_OR;
          3'b001: begin
            dec_sel = ALU_SLL;
            dec_b   = {{(XLEN-5){1'b0}}, in_imm[4:0]};
          end
          default: begin
            dec_we  = 1'b0;
            dec_ill = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        dec_sel = ALU_ADD;
        dec_we  = 1'b1;
      end
      OP_STORE: begin
        dec_sel = ALU_ADD;
      end
      OP_BRANCH: begin
        dec_sel = ALU_SUB;
        dec_b   = op_b;
      end
      OP_LUI: begin
        dec_sel = ALU_PASSB;
        dec_we  = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Flush only drops valid; the payload registers hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      data_a      <= '0;
      data_b      <= '0;
      alu_select  <= ALU_AND;
      store_data  <= '0;
      out_rd      <= '0;
      out_reg_we  <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      data_a      <= op_a;
      data_b      <= dec_b;
      alu_select  <= dec_sel;
      store_data  <= op_b;
      out_rd      <= in_rd;
      out_reg_we  <= dec_we && (in_rd != '0);
      out_illegal <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        exmem_we;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_we;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_a, data_b, store_data;
  logic [3:0]  alu_select;
  logic [4:0]  out_rd;
  logic        out_reg_we;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_a(data_a), .data_b(data_b), .alu_select(alu_select),
    .store_data(store_data), .out_rd(out_rd),
    .out_reg_we(out_reg_we), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [4:0] rd, input logic [31:0] imm);
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
    in_rd = rd; in_imm = imm;
  endtask

  task automatic no_fwd();
    exmem_we = 0; exmem_rd = 0; exmem_result = 0;
    memwb_we = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 1;
    no_fwd();
    instr(7'b0110011, 3'b000, 7'b0000000, 5'd3, 32'd5, 5'd4, 32'd7, 5'd1, 32'd0);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sel", {28'd0, alu_select}, 32'd0);
    check("rst_data_a", data_a, 32'd0);
    @(negedge clk); rst_n = 1;
    step();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // R-type ADD, no forwarding
    in_valid = 1;
    step();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_a", data_a, 32'd5);
    check("add_b", data_b, 32'd7);
    check("add_sel", {28'd0, alu_select}, 32'h2);
    check("add_we", {31'd0, out_reg_we}, 32'd1);
    check("add_ill", {31'd0, out_illegal}, 32'd0);

    // SUB with both stages matching rs1: EX/MEM wins
    instr(7'b0110011, 3'b000, 7'b0100000, 5'd3, 32'd5, 5'd4, 32'd7, 5'd1, 32'd0);
    exmem_we = 1; exmem_rd = 3; exmem_result = 100;
    memwb_we = 1; memwb_rd = 3; memwb_result = 200;
    step();
    check("fwd_exmem_a", data_a, 32'd100);
    check("sub_sel", {28'd0, alu_select}, 32'h6);
    check("sub_store", store_data, 32'd7);
    exmem_we = 0;
    step();
    check("fwd_memwb_a", data_a, 32'd200);
    // r0 never forwards
    in_rs1 = 0; exmem_we = 1; exmem_rd = 0; memwb_rd = 0;
    step();
    check("fwd_r0_a", data_a, 32'd5);
    // rs2 forwarded from MEM/WB
    in_rs1 = 3; exmem_we = 0; memwb_we = 1; memwb_rd = 4; memwb_result = 300;
    step();
    check("fwd_b", data_b, 32'd300);
    check("fwd_store", store_data, 32'd300);
    no_fwd();

    // Backpressure: ADDI imm=-1 captured, then stalled
    instr(7'b0010011, 3'b000, 7'b0000000, 5'd3, 32'd5, 5'd0, 32'd0, 5'd2, 32'hFFFFFFFF);
    step();
    check("addi_b", data_b, 32'hFFFFFFFF);
    out_ready = 0;
    instr(7'b0110011, 3'b111, 7'b0000000, 5'd6, 32'd9, 5'd7, 32'd3, 5'd8, 32'd0);
    #1;
    check("stall_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_b", data_b, 32'hFFFFFFFF);
      check("stall_a", data_a, 32'd5);
      check("stall_sel", {28'd0, alu_select}, 32'h2);
      check("stall_rd", {27'd0, out_rd}, 32'd2);
    end
    out_ready = 1;
    #1;
    check("unstall_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("and_sel", {28'd0, alu_select}, 32'h0);
    check("and_a", data_a, 32'd9);
    check("and_b", data_b, 32'd3);

    // Flush beats simultaneous capture
    flush = 1;
    instr(7'b0110111, 3'b000, 7'b0000000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h12345000);
    step();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_nocap", {28'd0, alu_select}, 32'h0);
    flush = 0; in_valid = 0;
    step();
    check("flush_idle", {31'd0, out_valid}, 32'd0);

    // LUI
    in_valid = 1;
    step();
    check("lui_sel", {28'd0, alu_select}, 32'hF);
    check("lui_b", data_b, 32'h12345000);
    check("lui_we", {31'd0, out_reg_we}, 32'd1);

    // SLLI uses imm[4:0] zero-extended
    instr(7'b0010011, 3'b001, 7'b0000000, 5'd1, 32'd1, 5'd0, 32'd0, 5'd9, 32'hFFFFFFE3);
    step();
    check("slli_sel", {28'd0, alu_select}, 32'h7);
    check("slli_b", data_b, 32'd3);

    // rd == 0 suppresses writeback
    instr(7'b0110011, 3'b000, 7'b0000000, 5'd1, 32'd1, 5'd2, 32'd2, 5'd0, 32'd0);
    step();
    check("rd0_we", {31'd0, out_reg_we}, 32'd0);

    // MUL
    instr(7'b0110011, 3'b000, 7'b0000001, 5'd1, 32'd6, 5'd2, 32'd7, 5'd3, 32'd0);
    step();
    check("mul_sel", {28'd0, alu_select}, 32'hC);

    // Store
    instr(7'b0100011, 3'b010, 7'b0000000, 5'd1, 32'h100, 5'd2, 32'hDEAD, 5'd4, 32'd8);
    step();
    check("st_sel", {28'd0, alu_select}, 32'h2);
    check("st_b", data_b, 32'd8);
    check("st_we", {31'd0, out_reg_we}, 32'd0);
    check("st_data", store_data, 32'hDEAD);

    // Branch
    instr(7'b1100011, 3'b000, 7'b0000000, 5'd1, 32'd10, 5'd2, 32'd11, 5'd4, 32'd16);
    step();
    check("br_sel", {28'd0, alu_select}, 32'h6);
    check("br_b", data_b, 32'd11);
    check("br_we", {31'd0, out_reg_we}, 32'd0);

    // Load
    instr(7'b0000011, 3'b010, 7'b0000000, 5'd1, 32'd10, 5'd2, 32'd11, 5'd4, 32'd20);
    step();
    check("ld_b", data_b, 32'd20);
    check("ld_we", {31'd0, out_reg_we}, 32'd1);

    // Illegal opcode
    instr(7'b1111111, 3'b000, 7'b0000000, 5'd1, 32'd1, 5'd2, 32'd2, 5'd6, 32'd0);
    step();
    check("ill_valid", {31'd0, out_valid}, 32'd1);
    check("ill_flag", {31'd0, out_illegal}, 32'd1);
    check("ill_we", {31'd0, out_reg_we}, 32'd0);
    check("ill_sel", {28'd0, alu_select}, 32'hF);

    // Asynchronous reset in the middle of a stall
    instr(7'b0110011, 3'b000, 7'b0000000, 5'd3, 32'd5, 5'd4, 32'd7, 5'd1, 32'd0);
    step();
    out_ready = 0; in_valid = 0;
    step();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_a", data_a, 32'd0);
    check("async_sel", {28'd0, alu_select}, 32'd0);
    @(negedge clk); rst_n = 1;
    step();
    check("rel_ready", {31'd0, in_ready}, 32'd1);
    check("rel_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Decodes opcode, funct3 and funct7 into the ALU's 4-bit select code.
- Picks the operands: register file, immediate, or values forwarded from the EX/MEM and MEM/WB stages.
- Registers the result behind a valid/ready handshake, so the ALU sees stable data_a, data_b and alu_select for a whole cycle.

Parameters:
- XLEN, 32, datapath width of operands, immediate and forwarded results.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_opcode  in  7  instruction opcode.
- in_funct3  in  3  instruction funct3.
- in_funct7  in  7  instruction funct7.
- in_rs1, in_rs2, in_rd  in  REG_ADDR_W  register indices.
- in_rs1_data, in_rs2_data  in  XLEN  register file read data.
- in_imm  in  XLEN  sign-extended immediate.
- exmem_we  in  1  EX/MEM writes a register.
- exmem_rd  in  REG_ADDR_W  EX/MEM destination.
- exmem_result  in  XLEN  EX/MEM value.
- memwb_we  in  1  MEM/WB writes a register.
- memwb_rd  in  REG_ADDR_W  MEM/WB destination.
- memwb_result  in  XLEN  MEM/WB value.
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  registered instruction valid.
- out_ready  in  1  EX stage accepts.
- data_a, data_b  out  XLEN  ALU operands.
- alu_select  out  4  ALU operation code.
- store_data  out  XLEN  forwarded rs2 value, used for stores.
- out_rd  out  REG_ADDR_W  destination index.
- out_reg_we  out  1  writeback enable.
- out_illegal  out  1  unsupported encoding flag.

Behaviour:
- Reset (rst_n low, asynchronous): every output register goes to 0, so out_valid=0 and alu_select=4'b0000. An instruction in flight is dropped. On the first edge after release, in_ready=1.
- Handshake: in_ready = !out_valid | out_ready, combinational. Capture when in_valid & in_ready. The registered outputs change only on capture, flush or reset. While out_valid & !out_ready, every output holds and is not re-forwarded.
- Throughput and latency: 1 instruction per cycle, 1-cycle latency from capture to out_valid.
- Flush: out_valid <= 0 and the same-cycle capture is suppressed. Flush wins over simultaneous capture.
- Forwarding, evaluated combinationally at capture for each source rsX:
  - EX/MEM if exmem_we & exmem_rd==rsX & rsX!=0.
  - else MEM/WB if memwb_we & memwb_rd==rsX & rsX!=0.
  - else the register file data.
  - EX/MEM has priority when both match. r0 always reads the register file value.
- Decode, with ALU codes taken from the shared package:
  - 0110011 (R-type):
    - f3=000: f7=0000000 gives ADD; 0100000 gives SUB; 0000001 gives MUL.
    - f3=111 with f7=0: AND.
    - f3=110 with f7=0: OR.
    - f3=001 with f7=0: SLL.
    - data_b = rs2 operand, reg_we=1.
  - 0010011 (I-type): f3 000/111/110/001 gives ADD/AND/OR/SLL. data_b=in_imm, reg_we=1. SLL uses in_imm[4:0], zero-extended.
  - 0000011 (load): ADD, data_b=imm, reg_we=1.
  - 0100011 (store): ADD, data_b=imm, reg_we=0, store_data = rs2 operand.
  - 1100011 (branch): SUB, data_b = rs2 operand, reg_we=0.
  - 0110111 (LUI): PASSB (4'b1111), data_b=imm, reg_we=1. The ALU default passes data_b through.
- data_a = rs1 operand in all cases.
- Any other encoding: alu_select=PASSB, reg_we=0, out_illegal=1, out_valid still asserted.
- out_reg_we is forced 0 when in_rd==0.
- store_data is always the forwarded rs2 operand.

Decomposition:
- Package alu_pkg holds:
  - localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLL=4'b0111, ALU_MUL=4'b1100, ALU_PASSB=4'b1111.
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI.
  - XLEN default.
- Sub-module fwd_mux: a combinational operand-forwarding selector, instantiated twice (rs1 and rs2).
- Decode stays inline in this block.

Test Plan:
- R-type ADD, rs1=3 (data 5), rs2=4 (data 7), no forwarding, out_ready=1 -> next cycle out_valid=1, data_a=5, data_b=7, alu_select=0010, out_reg_we=1.
- SUB with exmem_we=1, exmem_rd=3, exmem_result=100, memwb_we=1, memwb_rd=3, memwb_result=200 -> data_a=100. Repeat with exmem_we=0 -> data_a=200. Repeat with rs1=0 and both matching rd=0 -> register file value.
- Backpressure: capture ADDI imm=-1, hold out_ready=0 for 3 cycles while driving new inputs -> in_ready=0, outputs stable, data_b=32'hFFFFFFFF. Raise out_ready -> next instruction captured the following edge.
- Flush asserted with out_valid=1 and in_valid=1 the same cycle -> out_valid=0 next cycle, nothing captured.
- LUI imm=32'h12345000 -> alu_select=1111, data_b=32'h12345000. Opcode 1111111 -> out_illegal=1, out_reg_we=0.
- Assert rst_n low mid-stall with out_valid=1 -> outputs zero immediately, without waiting for a clock edge. After release, in_ready=1.
